ay_mixer_dac: RTL and testbench

Time-multiplexed channel mixer that sits directly upstream of the PDM output stage. On each sample strobe it snapshots per-channel gate bits and 4-bit volumes, maps each volume through a logarithmic amplitude table, and serially sums the channels into one saturated linear value. That value drives the PDM modulator's `value` input and is held constant between samples.

---
 rtl/ay_pkg.sv | 19 +
 rtl/ay_volume_lut.sv | 11 +
 rtl/ay_mixer_dac.sv | 111 +++++++++++
 tb/tb_ay_mixer_dac.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ay_pkg.sv
// Shared constants and types for the AY mixer/DAC path: log amplitude table and mixer FSM states.
package ay_pkg;

  localparam int unsigned VOLUME_BITS = 4;
  localparam int unsigned AMP_BITS    = 8;

  // Roughly 3 dB per step; three full-scale channels sum to exactly 255.
  localparam logic [AMP_BITS-1:0] AMP [16] = '{
    8'd0,  8'd1,  8'd1,  8'd1,  8'd2,  8'd3,  8'd4,  8'd5,
    8'd8,  8'd11, 8'd15, 8'd21, 8'd30, 8'd43, 8'd60, 8'd85
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ay_volume_lut.sv
// Combinational volume code to linear amplitude lookup; shared with the envelope path.
module ay_volume_lut
  import ay_pkg::*;
(
  input  logic [VOLUME_BITS-1:0] code,
  output logic [AMP_BITS-1:0]    amp_c
);

  assign amp_c = AMP[code];

endmodule

// File: rtl/ay_mixer_dac.sv
// Serial channel mixer: snapshots gates/volumes on a strobe, sums one channel per cycle,
// and presents a saturated, held amplitude to the PDM stage.
module ay_mixer_dac #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned VOLUME_BITS = 4,
  parameter int unsigned OUT_BITS    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sample_strobe,
  input  logic [CHANNELS-1:0]             channel_on,
  input  logic [CHANNELS*VOLUME_BITS-1:0] volume,
  output logic [OUT_BITS-1:0]             value,
  output logic                            value_valid,
  output logic                            busy,
  output logic                            overrun
);

  import ay_pkg::*;

  localparam int unsigned ACC_W = OUT_BITS + 2;
  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [ACC_W-1:0] MAX_OUT  = ACC_W'((1 << OUT_BITS) - 1);

  state_t                            state;
  logic [IDX_W-1:0]                  idx;
  logic [ACC_W-1:0]                  acc;
  logic [CHANNELS-1:0]               on_q;
  logic [CHANNELS*VOLUME_BITS-1:0]   vol_q;

  logic [VOLUME_BITS-1:0]            code_c;
  logic                              gate_c;
  logic [AMP_BITS-1:0]               amp_c;
  logic [ACC_W-1:0]                  contrib_c;
  logic [OUT_BITS-1:0]               sat_c;

  // Select the snapshot entry for the channel currently being accumulated.
  always_comb begin
    code_c = '0;
    gate_c = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (idx == IDX_W'(i)) begin
        code_c = vol_q[i*VOLUME_BITS +: VOLUME_BITS];
        gate_c = on_q[i];
      end
    end
  end

  ay_volume_lut u_lut (
    .code  (code_c),
    .amp_c (amp_c)
  );

  assign contrib_c = gate_c ? (ACC_W'(amp_c) << (OUT_BITS - AMP_BITS)) : '0;
  assign sat_c     = (acc > MAX_OUT) ? '1 : acc[OUT_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      on_q        <= '0;
      vol_q       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_strobe) begin
            on_q  <= channel_on;
            vol_q <= volume;
            acc   <= '0;
            idx   <= '0;
            state <= ACC;
            busy  <= 1'b1;
          end
        end
        ACC: begin
          if (sample_strobe) overrun <= 1'b1;
          acc <= acc + contrib_c;
          if (idx == LAST_IDX) state <= DONE;
          else                 idx   <= idx + 1'b1;
        end
        DONE: begin
          value       <= sat_c;
          value_valid <= 1'b1;
          // A strobe landing here is the back-to-back case and is accepted.
          if (sample_strobe) begin
            on_q  <= channel_on;
            vol_q <= volume;
            acc   <= '0;
            idx   <= '0;
            state <= ACC;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ay_mixer_dac.sv
// Randomized self-checking bench for ay_mixer_dac against a table-sum reference model.
module tb_ay_mixer_dac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_strobe;
  logic [2:0]  channel_on;
  logic [11:0] volume;
  logic [7:0]  value;
  logic        value_valid, busy, overrun;

  logic        strobe4;
  logic [3:0]  on4;
  logic [15:0] vol4;
  logic [7:0]  value4;
  logic        valid4, busy4, overrun4;

  int n_vec = 0;
  int n_err = 0;

  int amp_tb [16] = '{0, 1, 1, 1, 2, 3, 4, 5, 8, 11, 15, 21, 30, 43, 60, 85};

  always #5 clk = ~clk;

  ay_mixer_dac #(.CHANNELS(3)) dut (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
    .channel_on(channel_on), .volume(volume),
    .value(value), .value_valid(value_valid), .busy(busy), .overrun(overrun)
  );

  ay_mixer_dac #(.CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_strobe(strobe4),
    .channel_on(on4), .volume(vol4),
    .value(value4), .value_valid(valid4), .busy(busy4), .overrun(overrun4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input logic [3:0] on, input logic [15:0] vol, input int nch);
    int sum = 0;
    for (int i = 0; i < nch; i++) begin
      logic [3:0] v;
      v = vol[4*i +: 4];
      if (on[i]) sum += amp_tb[v];
    end
    return (sum > 255) ? 255 : sum;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Strobe one sample on the selected instance and wait (bounded) for its pulse.
  task automatic run_one(input string tag, input bit wide, input logic [3:0] on,
                         input logic [15:0] vol, input int exp_v);
    int n = 0;
    if (wide) begin on4 = on; vol4 = vol; strobe4 = 1'b1; end
    else begin channel_on = on[2:0]; volume = vol[11:0]; sample_strobe = 1'b1; end
    tick();
    strobe4 = 1'b0;
    sample_strobe = 1'b0;
    while (!(wide ? valid4 : value_valid) && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, wide ? 5 : 4);
    check({tag, "_val"}, wide ? int'(value4) : int'(value), exp_v);
  endtask

  initial begin
    int exp_q [$];
    int pulses;
    rst_n = 1'b0; sample_strobe = 1'b0; channel_on = '0; volume = '0;
    strobe4 = 1'b0; on4 = '0; vol4 = '0;
    tick(); tick();
    check("rst_value", int'(value), 0);
    check("rst_valid", int'(value_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // Full scale with three channels is exactly 255.
    run_one("full3", 1'b0, 4'b0111, 16'h0FFF, model(4'b0111, 16'h0FFF, 3));
    check("full3_abs", int'(value), 255);
    tick();
    check("full3_valid_drop", int'(value_valid), 0);
    check("full3_busy_low", int'(busy), 0);

    // Four channels at full scale sum to 340 and must saturate, not wrap.
    run_one("sat4", 1'b1, 4'b1111, 16'hFFFF, model(4'b1111, 16'hFFFF, 4));
    check("sat4_abs", int'(value4), 255);

    run_one("gate", 1'b0, 4'b0101, 16'h00C8, 8);

    // Back-to-back: a strobe in the DONE cycle is accepted without overrun.
    channel_on = 3'b111; volume = 12'h9AB; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    channel_on = 3'b011; volume = 12'h0F5;
    tick(); tick(); tick();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check("b2b_first_valid", int'(value_valid), 1);
    check("b2b_first_val", int'(value), model(4'b0111, 16'h09AB, 3));
    check("b2b_busy", int'(busy), 1);
    tick(); tick(); tick(); tick();
    check("b2b_second_valid", int'(value_valid), 1);
    check("b2b_second_val", int'(value), model(4'b0011, 16'h00F5, 3));
    check("b2b_no_overrun", int'(overrun), 0);
    tick();

    // Snapshot isolation plus a strobe while accumulating.
    channel_on = 3'b111; volume = 12'hEDC; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    channel_on = 3'b000; volume = 12'h000;
    tick();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check("ovr_set", int'(overrun), 1);
    tick(); tick();
    check("snap_valid", int'(value_valid), 1);
    check("snap_val", int'(value), model(4'b0111, 16'h0EDC, 3));
    tick();

    // Async reset mid-accumulation clears everything immediately.
    channel_on = 3'b111; volume = 12'h777; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_value", int'(value), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_overrun", int'(overrun), 0);
    check("arst_valid", int'(value_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (value_valid) pulses++;
    end
    check("arst_no_pulse", pulses, 0);
    check("arst_value_held", int'(value), 0);

    // Random stream with a strobe every 4 cycles.
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      logic [3:0]  ron;
      logic [15:0] rvol;
      ron  = 4'($urandom_range(0, 7));
      rvol = 16'($urandom_range(0, 4095));
      channel_on = ron[2:0]; volume = rvol[11:0]; sample_strobe = 1'b1;
      exp_q.push_back(model(ron, rvol, 3));
      for (int t = 0; t < 4; t++) begin
        tick();
        sample_strobe = 1'b0;
        if (value_valid) begin
          pulses++;
          if (exp_q.size() > 0) check("rand_val", int'(value), exp_q.pop_front());
          else check("rand_extra_pulse", 1, 0);
        end
      end
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      if (value_valid) begin
        pulses++;
        if (exp_q.size() > 0) check("rand_val", int'(value), exp_q.pop_front());
        else check("rand_extra_pulse", 1, 0);
      end
    end
    check("rand_pulses", pulses, 40);
    check("rand_no_overrun", int'(overrun), 0);
    check("rand_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
